// File: rtl/evm_pkg.sv
// Shared types and helpers for the evm_multi voting machine core.
package evm_pkg;

    // Top-level controller states
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOCK,
        SCAN,
        DONE
    } evm_state_t;

    // Width of a candidate index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of buttons pressed; the caller zero-extends to 16 bits
    function automatic int onehot_cnt(input logic [15:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/evm_edge_det.sv
// Rising-edge detector: registers the input and flags 0->1 transitions.
module evm_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] d_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) d_q <= '0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/evm_multi.sv
// Electronic voting machine core: session control, saturating tallies,
// sequential winner scan. Optional ARMED timeout built with EVM_TIMEOUT_EN.
module evm_multi
    import evm_pkg::*;
#(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
`ifdef EVM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      auth,
    input  logic [N_CAND-1:0]         vote,
    input  logic                      voting_on,
    input  logic [idx_w(N_CAND)-1:0]  rd_idx,
    output logic [CNT_W-1:0]          rd_count,
    output logic [CNT_W-1:0]          total,
    output logic                      ready,
    output logic                      voted,
    output logic                      invalid,
    output logic                      sat,
`ifdef EVM_TIMEOUT_EN
    output logic                      timeout,
`endif
    output logic                      closed,
    output logic                      result_valid,
    output logic [idx_w(N_CAND)-1:0]  winner,
    output logic                      tie
);

    localparam int IW = idx_w(N_CAND);
    localparam logic [CNT_W-1:0] CMAX = '1;

    evm_state_t        state;
    logic [CNT_W-1:0]  tally [N_CAND];
    logic [CNT_W-1:0]  max_r;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     win_r;
    logic              tie_r;
    logic [N_CAND-1:0] vote_rise;
    logic              auth_rise;
    int                press_cnt;
    logic              accept;
    logic              multi;
    logic [IW-1:0]     accept_idx;

`ifdef EVM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tmr;
    logic          expire;
    assign expire = (tmr == TW'(TIMEOUT_CYC - 1));
`endif

    evm_edge_det #(.W(N_CAND)) u_vote_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (vote),
        .rise (vote_rise)
    );

    evm_edge_det #(.W(1)) u_auth_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (auth),
        .rise (auth_rise)
    );

    assign press_cnt = onehot_cnt(16'(vote));
    assign accept    = (press_cnt == 1) && (|(vote & vote_rise));
    assign multi     = (press_cnt > 1) && (|vote_rise);

    // Index of the pressed button; only meaningful when exactly one is pressed
    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch).
        accept_idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (vote[i]) accept_idx = IW'(i);
        end
    end

    // Session FSM, tally updates and winner scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            // NOTE: the tally array is cleared by reset because a fresh election must start at zero.
            for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
            total    <= '0;
            voted    <= 1'b0;
            invalid  <= 1'b0;
            sat      <= 1'b0;
            max_r    <= '0;
            scan_idx <= '0;
            win_r    <= '0;
            tie_r    <= 1'b0;
`ifdef EVM_TIMEOUT_EN
            tmr      <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            voted   <= 1'b0;
            invalid <= 1'b0;
`ifdef EVM_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!voting_on) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else if (auth_rise) begin
                        state <= ARMED;
`ifdef EVM_TIMEOUT_EN
                        tmr   <= '0;
`endif
                    end
                end
                ARMED: begin
                    if (!voting_on) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else if (accept) begin
                        if (tally[accept_idx] == CMAX) sat <= 1'b1;
                        else tally[accept_idx] <= tally[accept_idx] + 1'b1;
                        if (total == CMAX) sat <= 1'b1;
                        else total <= total + 1'b1;
                        voted <= 1'b1;
                        state <= LOCK;
                    end
`ifdef EVM_TIMEOUT_EN
                    else if (expire) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
`endif
                    else begin
                        if (multi) invalid <= 1'b1;
`ifdef EVM_TIMEOUT_EN
                        tmr <= tmr + 1'b1;
`endif
                    end
                end
                LOCK: begin
                    if (!voting_on) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                    end else if (vote == '0) begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (scan_idx == '0) begin
                        max_r <= tally[0];
                        win_r <= '0;
                        tie_r <= 1'b0;
                    end else if (tally[scan_idx] > max_r) begin
                        max_r <= tally[scan_idx];
                        win_r <= scan_idx;
                        tie_r <= 1'b0;
                    end else if (tally[scan_idx] == max_r) begin
                        tie_r <= 1'b1;
                    end
                    if (scan_idx == IW'(N_CAND - 1)) state <= DONE;
                    else scan_idx <= scan_idx + 1'b1;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready        = (state == ARMED);
    assign closed       = (state == SCAN) || (state == DONE);
    assign result_valid = (state == DONE);
    assign winner       = result_valid ? win_r : '0;
    assign tie          = result_valid && tie_r;
    assign rd_count     = (int'(rd_idx) < N_CAND) ? tally[rd_idx] : '0;

endmodule
